// File: rtl/pc_sequencer.sv
// Program-counter unit with stall, circular return stack, and a single-level
// interrupt that saves the architectural next pc into epc.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = ADDR_WIDTH'(16),
    parameter int                    STACK_DEPTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             branch,
    input  logic                             cond,
    input  logic                             jump,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             iret,
    input  logic [ADDR_WIDTH-1:0]            target,
    input  logic                             irq,
    output logic [ADDR_WIDTH-1:0]            pc,
    output logic                             irq_ack,
    output logic                             in_irq,
    output logic [$clog2(STACK_DEPTH):0]     depth,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic [PW-1:0]         sp_q, sp_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic                  in_irq_q, in_irq_d;
    logic                  irq_ack_q, irq_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic [ADDR_WIDTH-1:0] seq;
    logic [ADDR_WIDTH-1:0] top;
    logic [ADDR_WIDTH-1:0] nxt;
    logic                  push;
    logic                  take;

    // sp_q points at the next free slot; the top entry sits just below it.
    assign seq = pc_q + ADDR_WIDTH'(1);
    assign top = stack_q[sp_q - PW'(1)];

    always_comb begin
        pc_d        = pc_q;
        epc_d       = epc_q;
        sp_d        = sp_q;
        depth_d     = depth_q;
        in_irq_d    = in_irq_q;
        irq_ack_d   = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        nxt         = seq;
        push        = 1'b0;
        take        = 1'b0;

        if (!stall) begin
            if (iret) begin
                if (in_irq_q) begin
                    nxt      = epc_q;
                    in_irq_d = 1'b0;
                end
            end else if (ret) begin
                if (depth_q != '0) begin
                    nxt     = top;
                    sp_d    = sp_q - PW'(1);
                    depth_d = depth_q - DW'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end else if (call) begin
                // A push onto a full stack overwrites the oldest entry.
                push = 1'b1;
                sp_d = sp_q + PW'(1);
                nxt  = target;
                if (depth_q == FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    depth_d = depth_q + DW'(1);
                end
            end else if (jump || (branch && cond)) begin
                nxt = target;
            end

            take = irq && !in_irq_q && !call && !ret && !iret;
            if (take) begin
                epc_d     = nxt;
                pc_d      = IRQ_VECTOR;
                in_irq_d  = 1'b1;
                irq_ack_d = 1'b1;
            end else begin
                pc_d = nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            epc_q       <= '0;
            sp_q        <= '0;
            depth_q     <= '0;
            in_irq_q    <= 1'b0;
            irq_ack_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            in_irq_q    <= in_irq_d;
            irq_ack_q   <= irq_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack contents survive reset; only the pointer and depth are cleared.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_q[sp_q] <= seq;
        end
    end

    assign pc        = pc_q;
    assign irq_ack   = irq_ack_q;
    assign in_irq    = in_irq_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance for sequencing, stack and
// interrupt behaviour, and a 4-bit instance for wrap, stall and reset priority.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, branch, cond, jump, call, ret, iret, irq;
    logic [31:0] target;
    logic [31:0] pc;
    logic        irq_ack, in_irq, overflow, underflow;
    logic [3:0]  depth;

    logic        rst4, stall4, jump4;
    logic [3:0]  tgt4;
    logic [3:0]  pc4;
    logic        irq_ack4, in_irq4, overflow4, underflow4;
    logic [3:0]  depth4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .IRQ_VECTOR(32'h10), .STACK_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .cond(cond),
        .jump(jump), .call(call), .ret(ret), .iret(iret), .target(target),
        .irq(irq), .pc(pc), .irq_ack(irq_ack), .in_irq(in_irq), .depth(depth),
        .overflow(overflow), .underflow(underflow)
    );

    pc_sequencer #(
        .ADDR_WIDTH(4), .RESET_VECTOR(4'h5), .IRQ_VECTOR(4'h3), .STACK_DEPTH(8)
    ) dut4 (
        .clk(clk), .reset(rst4), .stall(stall4), .branch(1'b0), .cond(1'b0),
        .jump(jump4), .call(1'b0), .ret(1'b0), .iret(1'b0), .target(tgt4),
        .irq(1'b0), .pc(pc4), .irq_ack(irq_ack4), .in_irq(in_irq4), .depth(depth4),
        .overflow(overflow4), .underflow(underflow4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch = 0; cond = 0; jump = 0; call = 0; ret = 0; iret = 0; irq = 0;
        target = '0;
    endtask

    initial begin
        idle();
        reset = 1; stall = 1;
        rst4 = 1; stall4 = 0; jump4 = 0; tgt4 = '0;

        // Test 1: reset with stall asserted, then free-running sequence
        step(); step();
        check("rst_pc", pc, 0);
        check("rst_depth", depth, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_in_irq", in_irq, 0);
        check("rst_ack", irq_ack, 0);
        check("rst4_pc", pc4, 4'h5);
        reset = 0; stall = 0; rst4 = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("seq_%0d", i), pc, i);
        end

        // Test 2: call/ret from pc=5, then a ret on the empty stack
        step(); step();
        check("pc_5", pc, 5);
        call = 1; target = 32'h40;
        step();
        check("call_pc", pc, 32'h40);
        check("call_depth", depth, 1);
        call = 0; ret = 1;
        step();
        check("ret_pc", pc, 6);
        check("ret_depth", depth, 0);
        step();
        check("unf_pc", pc, 7);
        check("unf_flag", underflow, 1);
        check("unf_depth", depth, 0);
        ret = 0;

        // Test 3: nine back-to-back calls overflow the 8-entry stack.
        // Pushes are 1, 0x101..0x108; the ninth overwrites the oldest (1).
        jump = 1; target = 32'h0;
        step();
        check("jmp0_pc", pc, 0);
        jump = 0; call = 1;
        for (int i = 0; i < 9; i++) begin
            target = 32'h100 + i;
            step();
        end
        call = 0;
        check("ovf_pc", pc, 32'h108);
        check("ovf_flag", overflow, 1);
        check("ovf_depth", depth, 8);
        ret = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("pop_%0d", k), pc, 32'h108 - k);
        end
        ret = 0;
        check("pop_depth", depth, 0);
        check("unf_sticky", underflow, 1);
        check("ovf_sticky", overflow, 1);

        // Test 4: taken branch with irq; epc captures the branch target
        jump = 1; target = 32'h20;
        step();
        check("jmp20_pc", pc, 32'h20);
        jump = 0; branch = 1; cond = 1; target = 32'h30; irq = 1;
        step();
        check("irq_ack", irq_ack, 1);
        check("irq_pc", pc, 32'h10);
        check("irq_in", in_irq, 1);
        branch = 0; cond = 0;
        step();
        check("irq_masked_ack", irq_ack, 0);
        check("irq_masked_pc", pc, 32'h11);
        iret = 1;
        step();
        check("iret_pc", pc, 32'h30);
        check("iret_in", in_irq, 0);
        check("iret_ack", irq_ack, 0);
        iret = 0;
        step();
        check("retake_ack", irq_ack, 1);
        check("retake_pc", pc, 32'h10);
        irq = 0; iret = 1;
        step();
        check("retake_ret", pc, 32'h31);
        iret = 0;
        step();
        check("ack_pulse", irq_ack, 0);

        // Test 5: call beats irq; the irq is taken on the next cycle
        jump = 1; target = 32'h08;
        step();
        check("jmp8_pc", pc, 32'h08);
        jump = 0; call = 1; irq = 1; target = 32'h50;
        step();
        check("call_win_pc", pc, 32'h50);
        check("call_win_ack", irq_ack, 0);
        check("call_win_depth", depth, 1);
        call = 0;
        step();
        check("late_irq_ack", irq_ack, 1);
        check("late_irq_pc", pc, 32'h10);
        stall = 1; iret = 1;
        step(); step();
        check("stall_pc", pc, 32'h10);
        check("stall_ack", irq_ack, 0);
        check("stall_in", in_irq, 1);
        stall = 0; irq = 0;
        step();
        check("late_iret_pc", pc, 32'h51);
        iret = 0;

        // Test 6: 4-bit wrap, stall hold and reset over stall
        jump4 = 1; tgt4 = 4'hF;
        step();
        check("w4_pc15", pc4, 4'hF);
        jump4 = 0;
        step();
        check("w4_wrap", pc4, 4'h0);
        stall4 = 1; jump4 = 1; tgt4 = 4'h9;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("w4_stall_%0d", i), pc4, 4'h0);
        end
        rst4 = 1;
        step();
        check("w4_rst_pc", pc4, 4'h5);
        check("w4_rst_depth", depth4, 0);
        rst4 = 0; stall4 = 0; jump4 = 0;
        step();
        check("w4_after_rst", pc4, 4'h6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
